alu_issue_ctrl: RTL and testbench

// - Initiator side of the ALU interface: accepts one RV32I OP/OP-IMM instruction at a time,

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the ALU issue controller and its register file.
package riscv_pkg;

  localparam int DEF_XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  // Immediate shifts take a zero-extended shamt instead of the sign-extended imm.
  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two async operand read ports, one async debug read port,
// one synchronous write port. x0 has no storage and always reads 0.
module alu_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  input  logic [4:0]      raddr_b,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  output logic [XLEN-1:0] dbg_rdata
);

  logic [XLEN-1:0] regs [1:NREGS-1];

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs[gi] <= '0;
        end else if (we && (waddr == 5'(gi))) begin
          regs[gi] <= wdata;
        end
      end
    end
  endgenerate

  // Reads return pre-write contents during a same-cycle write.
  assign rdata_a   = (raddr_a   == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b   = (raddr_b   == 5'd0) ? '0 : regs[raddr_b];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Minimal execute loop: accepts one OP/OP-IMM instruction, drives the external ALU,
// waits ALU_LAT cycles and writes the result back into the internal register file.
module alu_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREGS   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [2:0]      alu_funct3,
  output logic            alu_funct7,
  input  logic [XLEN-1:0] alu_rd,
  input  logic            alu_z,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            z_flag,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  // ALU_LAT=0 still needs one EXEC cycle, so the last count is clamped at 0.
  localparam logic [2:0] LAT_LAST = (ALU_LAT == 0) ? 3'd0 : 3'(ALU_LAT - 1);

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [4:0]      rd_reg, rd_next;
  logic [XLEN-1:0] rs1_reg, rs1_next;
  logic [XLEN-1:0] rs2_reg, rs2_next;
  logic [2:0]      f3_reg, f3_next;
  logic            f7_reg, f7_next;
  logic            wb_valid_reg, wb_valid_next;
  logic [4:0]      wb_addr_reg, wb_addr_next;
  logic [XLEN-1:0] wb_data_reg, wb_data_next;
  logic            z_reg, z_next;
  logic            illegal_reg, illegal_next;

  logic [XLEN-1:0] rf_a, rf_b;
  logic [6:0]      opcode;
  logic [2:0]      dec_f3;
  logic [XLEN-1:0] imm_sext, imm_shamt;

  assign opcode    = instr[6:0];
  assign dec_f3    = instr[14:12];
  assign imm_sext  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_shamt = {{(XLEN-5){1'b0}}, instr[24:20]};

  alu_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (wb_valid_reg),
    .waddr     (wb_addr_reg),
    .wdata     (wb_data_reg),
    .raddr_a   (instr[19:15]),
    .raddr_b   (instr[24:20]),
    .dbg_raddr (dbg_raddr),
    .rdata_a   (rf_a),
    .rdata_b   (rf_b),
    .dbg_rdata (dbg_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rd_reg       <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      f3_reg       <= '0;
      f7_reg       <= 1'b0;
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      z_reg        <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rd_reg       <= rd_next;
      rs1_reg      <= rs1_next;
      rs2_reg      <= rs2_next;
      f3_reg       <= f3_next;
      f7_reg       <= f7_next;
      wb_valid_reg <= wb_valid_next;
      wb_addr_reg  <= wb_addr_next;
      wb_data_reg  <= wb_data_next;
      z_reg        <= z_next;
      illegal_reg  <= illegal_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rd_next       = rd_reg;
    rs1_next      = rs1_reg;
    rs2_next      = rs2_reg;
    f3_next       = f3_reg;
    f7_next       = f7_reg;
    wb_valid_next = 1'b0;
    wb_addr_next  = wb_addr_reg;
    wb_data_next  = wb_data_reg;
    z_next        = z_reg;
    illegal_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (instr_valid) begin
          if (opcode == OPC_OP) begin
            rs1_next   = rf_a;
            rs2_next   = rf_b;
            f3_next    = dec_f3;
            f7_next    = instr[30];
            rd_next    = instr[11:7];
            cnt_next   = '0;
            state_next = EXEC;
          end else if (opcode == OPC_OP_IMM) begin
            rs1_next   = rf_a;
            rs2_next   = is_shift(dec_f3) ? imm_shamt : imm_sext;
            f3_next    = dec_f3;
            // imm[10] is only an opcode modifier for SRAI; elsewhere it is immediate data.
            f7_next    = (dec_f3 == F3_SR) && instr[30];
            rd_next    = instr[11:7];
            cnt_next   = '0;
            state_next = EXEC;
          end else begin
            illegal_next = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_reg == LAT_LAST) begin
          wb_valid_next = 1'b1;
          wb_addr_next  = rd_reg;
          wb_data_next  = alu_rd;
          z_next        = alu_z;
          state_next    = WB;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign instr_ready = (state_reg == IDLE);
  assign alu_rs1     = rs1_reg;
  assign alu_rs2     = rs2_reg;
  assign alu_funct3  = f3_reg;
  assign alu_funct7  = f7_reg;
  assign wb_valid    = wb_valid_reg;
  assign wb_addr     = wb_addr_reg;
  assign wb_data     = wb_data_reg;
  assign z_flag      = z_reg;
  assign illegal     = illegal_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural combinational ALU attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_rs1, alu_rs2, alu_rd;
  logic [2:0]  alu_funct3;
  logic        alu_funct7, alu_z;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        z_flag, illegal;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(32), .NREGS(32), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_rd(alu_rd), .alu_z(alu_z),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .z_flag(z_flag),
    .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  // ALU partner
  always_comb begin
    alu_rd = '0;
    case (alu_funct3)
      3'd0: alu_rd = alu_funct7 ? (alu_rs1 - alu_rs2) : (alu_rs1 + alu_rs2);
      3'd1: alu_rd = alu_rs1 << alu_rs2[4:0];
      3'd2: alu_rd = {31'b0, $signed(alu_rs1) < $signed(alu_rs2)};
      3'd3: alu_rd = {31'b0, alu_rs1 < alu_rs2};
      3'd4: alu_rd = alu_rs1 ^ alu_rs2;
      3'd5: alu_rd = alu_funct7 ? 32'($signed(alu_rs1) >>> alu_rs2[4:0]) : (alu_rs1 >> alu_rs2[4:0]);
      3'd6: alu_rd = alu_rs1 | alu_rs2;
      default: alu_rd = alu_rs1 & alu_rs2;
    endcase
  end
  assign alu_z = (alu_rd == 32'd0);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        z;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] xr[32];
  int          tests = 0;
  int          fails = 0;
  int          pushed = 0;
  int          wb_seen = 0;
  int          exp_illegal = 0;
  int          illegal_seen = 0;
  int          rdy_run = 0;
  logic        rdy_chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %h", tag, got);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Instruction-level reference: architectural semantics of the accepted instruction.
  task automatic model_issue(input logic [31:0] ins);
    logic [31:0] a, b, r;
    logic        is_op;
    exp_t        e;
    is_op = (ins[6:0] == 7'b0110011);
    if (!is_op && ins[6:0] != 7'b0010011) begin
      exp_illegal++;
      return;
    end
    a = xr[ins[19:15]];
    if (is_op) b = xr[ins[24:20]];
    else if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) b = {27'b0, ins[24:20]};
    else b = {{20{ins[31]}}, ins[31:20]};
    case (ins[14:12])
      3'd0: r = (is_op && ins[30]) ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    if (ins[11:7] != 5'd0) xr[ins[11:7]] = r;
    e.addr = ins[11:7];
    e.data = r;
    e.z    = (r == 32'd0);
    sb_q.push_back(e);
    pushed++;
  endtask

  task automatic issue(input logic [31:0] ins);
    int g = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ins;
    while (!instr_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("issue_ready", 32'(instr_ready), 32'd1);
    model_issue(ins);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int g = 0;
    do begin
      @(negedge clk);
      #1;
      g++;
    end while ((sb_q.size() != 0 || !instr_ready) && g < 30);
    chk("done_wait", 32'(instr_ready && (sb_q.size() == 0)), 32'd1);
  endtask

  task automatic run1(input logic [31:0] ins);
    issue(ins);
    instr_valid = 1'b0;
    wait_done();
  endtask

  task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_raddr = a;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_rs1", alu_rs1, 32'd0);
    chk("rst_rs2", alu_rs2, 32'd0);
    chk("rst_f3", 32'(alu_funct3), 32'd0);
    chk("rst_f7", 32'(alu_funct7), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wba", 32'(wb_addr), 32'd0);
    chk("rst_wbd", wb_data, 32'd0);
    chk("rst_z", 32'(z_flag), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    dbg("rst_dbg_x1", 5'd1, 32'd0);
  endtask

  // Output monitor: pops the scoreboard on every writeback pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (wb_valid) begin
        wb_seen++;
        if (sb_q.size() == 0) begin
          chk("wb_unexpected_addr", 32'(wb_addr), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("wb_addr", 32'(wb_addr), 32'(e.addr));
          chk("wb_data", wb_data, e.data);
          chk("wb_z", 32'(z_flag), 32'(e.z));
        end
      end
      if (illegal) illegal_seen++;
      if (rdy_chk_en) begin
        if (!instr_ready) rdy_run++;
        else if (rdy_run != 0) begin
          chk("rdy_low_cycles", 32'(rdy_run), 32'd2);
          rdy_run = 0;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) xr[i] = '0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_raddr   = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    run1(enc_i(12'd20, 5'd0, 3'd0, 5'd1));
    run1(enc_i(12'd30, 5'd0, 3'd0, 5'd2));
    run1(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    dbg("dbg_x3", 5'd3, 32'd50);

    run1(enc_r(7'h20, 5'd1, 5'd1, 3'd0, 5'd4));
    chk("z_after_sub", 32'(z_flag), 32'd1);
    run1(enc_i(12'hFFF, 5'd0, 3'd0, 5'd5));
    chk("z_after_addi", 32'(z_flag), 32'd0);
    dbg("dbg_x5", 5'd5, 32'hFFFF_FFFF);

    run1(enc_i({7'h20, 5'd4}, 5'd5, 3'd5, 5'd6));
    run1(enc_i({7'h00, 5'd28}, 5'd5, 3'd5, 5'd7));
    run1(enc_i(12'd3, 5'd1, 3'd1, 5'd8));
    dbg("dbg_x6", 5'd6, 32'hFFFF_FFFF);
    dbg("dbg_x7", 5'd7, 32'h0000_000F);
    dbg("dbg_x8", 5'd8, 32'd160);

    run1(enc_i(12'd5, 5'd0, 3'd0, 5'd0));
    dbg("dbg_x0", 5'd0, 32'd0);

    // JAL is not handled: expect an illegal pulse and no writeback
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 32'h0000_006F;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    model_issue(32'h0000_006F);
    @(negedge clk);
    chk("jal_illegal", 32'(illegal), 32'd1);
    chk("jal_no_wb", 32'(wb_valid), 32'd0);
    chk("jal_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    chk("jal_illegal_pulse", 32'(illegal), 32'd0);

    // Valid held high across three dependent instructions
    rdy_run    = 0;
    rdy_chk_en = 1'b1;
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd10));
    issue(enc_r(7'h00, 5'd1, 5'd10, 3'd4, 5'd11));
    issue(enc_r(7'h00, 5'd1, 5'd5, 3'd2, 5'd12));
    instr_valid = 1'b0;
    wait_done();
    rdy_chk_en = 1'b0;
    dbg("dbg_x11", 5'd11, 32'd38);

    run1(enc_r(7'h00, 5'd1, 5'd5, 3'd3, 5'd13));
    run1(enc_i(12'h0F0, 5'd5, 3'd7, 5'd14));
    run1(enc_i(12'd0, 5'd5, 3'd2, 5'd15));
    run1(enc_r(7'h20, 5'd3, 5'd11, 3'd5, 5'd16));

    // Asynchronous reset in the middle of EXEC aborts the instruction
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd9);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("exec_entered", 32'(instr_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < 32; i++) xr[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    dbg("dbg_x9_after_rst", 5'd9, 32'd0);
    chk("ready_after_rst", 32'(instr_ready), 32'd1);

    run1(enc_i(12'd7, 5'd0, 3'd0, 5'd1));
    dbg("dbg_x1_resume", 5'd1, 32'd7);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("wb_count", 32'(wb_seen), 32'(pushed));
    chk("illegal_count", 32'(illegal_seen), 32'(exp_illegal));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
